// File: rtl/cpu_pkg.sv
// Shared CPU definitions: program address width and address type used by
// both the program counter and the return-address stack.
package cpu_pkg;

    localparam int CNTR_WIDTH_DEF = 8;

    typedef logic [CNTR_WIDTH_DEF-1:0] pc_t;

endpackage : cpu_pkg

// File: rtl/stack_mem.sv
// Register array for the return-address stack: synchronous write,
// asynchronous read so the top entry is visible in the same cycle.
module stack_mem
    import cpu_pkg::*;
#(
    parameter int WIDTH = CNTR_WIDTH_DEF,
    parameter int DEPTH = 8,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one entry per write strobe; contents are never reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Combinational read of the addressed entry.
    always_comb begin
        rdata = mem_q[raddr];
    end

endmodule : stack_mem

// File: rtl/return_stack.sv
// Return-address stack: pointer, sticky error flags and next-state logic.
// Push stores the calling address, pop exposes the next-older entry, and
// push-while-full / pop-while-empty only raise sticky flags.
module return_stack
    import cpu_pkg::*;
#(
    parameter int CNTR_WIDTH = CNTR_WIDTH_DEF,
    parameter int DEPTH      = 8,
    parameter int LVL_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  call,
    input  logic                  ret_f,
    input  logic [CNTR_WIDTH-1:0] pc_in,
    output logic [CNTR_WIDTH-1:0] ret_data,
    output logic [LVL_WIDTH-1:0]  level,
    output logic                  empty,
    output logic                  full,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [LVL_WIDTH-1:0]  level_q, level_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  empty_s, full_s;
    logic                  we_s;
    logic [AW-1:0]         waddr_s;
    logic [AW-1:0]         raddr_s;
    logic [CNTR_WIDTH-1:0] rdata_s;

    stack_mem #(
        .WIDTH (CNTR_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (we_s),
        .waddr (waddr_s),
        .wdata (pc_in),
        .raddr (raddr_s),
        .rdata (rdata_s)
    );

    // Status decode and top-of-stack address; the read address is parked
    // at 0 when empty so it never indexes past the array.
    always_comb begin
        empty_s = (level_q == {LVL_WIDTH{1'b0}});
        full_s  = (level_q == LVL_WIDTH'(DEPTH));
        if (empty_s) begin
            raddr_s = {AW{1'b0}};
        end else begin
            raddr_s = AW'(level_q - LVL_WIDTH'(1));
        end
    end

    // Next-state decode for pointer, flags and the array write port.
    always_comb begin
        level_d = level_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        we_s    = 1'b0;
        waddr_s = AW'(level_q);
        case ({call, ret_f})
            2'b10: begin
                if (!full_s) begin
                    we_s    = 1'b1;
                    waddr_s = AW'(level_q);
                    level_d = level_q + LVL_WIDTH'(1);
                end else begin
                    // Drop the new address so older return points survive.
                    ovf_d = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_s) begin
                    level_d = level_q - LVL_WIDTH'(1);
                end else begin
                    udf_d = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_s) begin
                    // Tail call: overwrite the current top in place.
                    we_s    = 1'b1;
                    waddr_s = AW'(level_q - LVL_WIDTH'(1));
                end else begin
                    // Nothing to return to: record it, then act as a push.
                    we_s    = 1'b1;
                    waddr_s = {AW{1'b0}};
                    level_d = LVL_WIDTH'(1);
                    udf_d   = 1'b1;
                end
            end
            default: begin
                level_d = level_q;
            end
        endcase
    end

    // State registers; reset clears pointer and sticky flags only.
    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= {LVL_WIDTH{1'b0}};
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            level_q <= level_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Outputs: top entry is forced to 0 when empty so stale data never leaks.
    always_comb begin
        if (empty_s) begin
            ret_data = {CNTR_WIDTH{1'b0}};
        end else begin
            ret_data = rdata_s;
        end
        level     = level_q;
        empty     = empty_s;
        full      = full_s;
        overflow  = ovf_q;
        underflow = udf_q;
    end

endmodule : return_stack

// File: tb/tb_return_stack.sv
// Self-checking bench for return_stack: directed scenarios followed by
// randomized traffic, all compared against a queue-based reference model.
module tb_return_stack;

    localparam int CW    = 8;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          call = 1'b0;
    logic          ret_f = 1'b0;
    logic [CW-1:0] pc_in = '0;
    logic [CW-1:0] ret_data;
    logic [LW-1:0] level;
    logic          empty, full, overflow, underflow;

    int n_vec  = 0;
    int n_miss = 0;

    // reference model
    logic [CW-1:0] m_q[$];
    logic          m_ovf = 1'b0;
    logic          m_udf = 1'b0;

    return_stack #(.CNTR_WIDTH(CW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .call      (call),
        .ret_f     (ret_f),
        .pc_in     (pc_in),
        .ret_data  (ret_data),
        .level     (level),
        .empty     (empty),
        .full      (full),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic c, input logic r, input logic [CW-1:0] pc, input logic rs);
        if (rs) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else if (c && r) begin
            if (m_q.size() > 0) begin
                m_q[m_q.size()-1] = pc;
            end else begin
                m_q.push_back(pc);
                m_udf = 1'b1;
            end
        end else if (c) begin
            if (m_q.size() < DEPTH) m_q.push_back(pc);
            else m_ovf = 1'b1;
        end else if (r) begin
            if (m_q.size() > 0) void'(m_q.pop_back());
            else m_udf = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [CW-1:0] top;
        top = (m_q.size() > 0) ? m_q[m_q.size()-1] : '0;
        check({tag, ".ret_data"},  32'(ret_data),  32'(top));
        check({tag, ".level"},     32'(level),     32'(m_q.size()));
        check({tag, ".empty"},     32'(empty),     32'(m_q.size() == 0));
        check({tag, ".full"},      32'(full),      32'(m_q.size() == DEPTH));
        check({tag, ".overflow"},  32'(overflow),  32'(m_ovf));
        check({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
    endtask

    // Apply one cycle of inputs, advance the model, then compare at negedge.
    task automatic step(input string tag, input logic c, input logic r,
                        input logic [CW-1:0] pc, input logic rs);
        call  = c;
        ret_f = r;
        pc_in = pc;
        rst   = rs;
        @(posedge clk);
        model_update(c, r, pc, rs);
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        // reset
        step("rst0", 1'b0, 1'b0, 8'h00, 1'b1);
        step("rst1", 1'b1, 1'b1, 8'hAA, 1'b1);
        check("reset.level", 32'(level), 32'd0);
        check("reset.empty", 32'(empty), 32'd1);

        // pop on empty
        step("pop_empty", 1'b0, 1'b1, 8'h00, 1'b0);
        check("pop_empty.udf", 32'(underflow), 32'd1);
        step("rst_udf", 1'b0, 1'b0, 8'h00, 1'b1);
        check("rst_udf.udf", 32'(underflow), 32'd0);

        // nested calls
        step("push10", 1'b1, 1'b0, 8'h10, 1'b0);
        step("push20", 1'b1, 1'b0, 8'h20, 1'b0);
        step("push30", 1'b1, 1'b0, 8'h30, 1'b0);
        check("nest.level", 32'(level), 32'd3);
        check("nest.top",   32'(ret_data), 32'h30);
        step("pop1", 1'b0, 1'b1, 8'h00, 1'b0);
        check("nest.pop1", 32'(ret_data), 32'h20);
        step("pop2", 1'b0, 1'b1, 8'h00, 1'b0);
        check("nest.pop2", 32'(ret_data), 32'h10);
        step("pop3", 1'b0, 1'b1, 8'h00, 1'b0);
        check("nest.pop3", 32'(ret_data), 32'h00);
        check("nest.empty", 32'(empty), 32'd1);

        // overflow
        for (int i = 1; i <= DEPTH; i++) step("ovf_push", 1'b1, 1'b0, CW'(i), 1'b0);
        check("ovf.full", 32'(full), 32'd1);
        step("ovf_push9", 1'b1, 1'b0, 8'h09, 1'b0);
        check("ovf.flag",  32'(overflow), 32'd1);
        check("ovf.level", 32'(level), 32'd8);
        check("ovf.top",   32'(ret_data), 32'h08);
        for (int i = DEPTH; i >= 1; i--) begin
            check("ovf.popval", 32'(ret_data), 32'(i));
            step("ovf_pop", 1'b0, 1'b1, 8'h00, 1'b0);
        end
        step("rst2", 1'b0, 1'b0, 8'h00, 1'b1);

        // simultaneous call and return
        step("sim10", 1'b1, 1'b0, 8'h10, 1'b0);
        step("sim20", 1'b1, 1'b0, 8'h20, 1'b0);
        step("sim44", 1'b1, 1'b1, 8'h44, 1'b0);
        check("sim.level", 32'(level), 32'd2);
        check("sim.top",   32'(ret_data), 32'h44);
        step("sim_pop", 1'b0, 1'b1, 8'h00, 1'b0);
        check("sim.pop", 32'(ret_data), 32'h10);
        step("rst3", 1'b0, 1'b0, 8'h00, 1'b1);

        // simultaneous on empty
        step("sime05", 1'b1, 1'b1, 8'h05, 1'b0);
        check("sime.level", 32'(level), 32'd1);
        check("sime.top",   32'(ret_data), 32'h05);
        check("sime.udf",   32'(underflow), 32'd1);
        step("rst4", 1'b0, 1'b0, 8'h00, 1'b1);

        // reset mid-operation
        step("mid1", 1'b1, 1'b0, 8'h01, 1'b0);
        step("mid2", 1'b1, 1'b0, 8'h02, 1'b0);
        step("mid3", 1'b1, 1'b0, 8'h03, 1'b0);
        step("mid_rst", 1'b1, 1'b0, 8'h77, 1'b1);
        check("mid.level", 32'(level), 32'd0);
        check("mid.top",   32'(ret_data), 32'h00);
        step("mid11", 1'b1, 1'b0, 8'h11, 1'b0);
        check("mid.push", 32'(ret_data), 32'h11);

        // randomized traffic with phases biased toward filling and draining
        for (int i = 0; i < 3000; i++) begin
            int unsigned bias;
            logic c, r, rs;
            bias = ((i / 200) % 2 == 0) ? 70 : 30;
            c  = ($urandom_range(99) < bias);
            r  = ($urandom_range(99) < (100 - bias));
            rs = ($urandom_range(149) == 0);
            step("rand", c, r, CW'($urandom), rs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_return_stack

// File: doc/return_stack.md
# return_stack

Hardware return-address stack that feeds `ret_data` to the program counter. On a call it stores the address of the calling instruction. On a return it presents the most recent stored address; the counter then resumes at that address + 1. It sits beside the program counter and is driven by the same decoded `jmp`/`ret_f` control. It detects and flags overflow and underflow instead of corrupting state.

## Interface
Parameters:
- `CNTR_WIDTH`, 8: width of a program address; must match the program counter.
- `DEPTH`, 8: number of stack entries; ≥ 2, power of two not required.
- `LVL_WIDTH`, `$clog2(DEPTH+1)`: width of `level`; derived, not overridden.

Ports:
- `clk` in 1: single clock; all state changes on rising edge.
- `rst` in 1: reset is synchronous and active-high.
- `call` in 1: push request; the calling instruction's address is on `pc_in`.
- `ret_f` in 1: pop request; same signal that selects `ret_data` in the program counter.
- `pc_in` in CNTR_WIDTH: current program counter value (address of the call instruction).
- `ret_data` out CNTR_WIDTH: current top-of-stack entry; 0 when empty.
- `level` out LVL_WIDTH: number of valid entries.
- `empty` out 1: `level == 0`.
- `full` out 1: `level == DEPTH`.
- `overflow` out 1: sticky; set by a push while full.
- `underflow` out 1: sticky; set by a pop while empty.

## Operation
- State: entry array `DEPTH × CNTR_WIDTH`, pointer `level`, two sticky flags.
- `ret_data` = `mem[level-1]` when `level > 0`, else 0.
  - Combinational from registers, so it is valid in the same cycle `ret_f` is asserted. The program counter samples it at that edge.
- Per rising edge, with `rst` low:
  - `call` only, not full: `mem[level] <= pc_in`, `level + 1`.
  - `call` only, full: no write, `level` unchanged, `overflow <= 1`. The new address is dropped and the older entries are preserved.
  - `ret_f` only, not empty: `level - 1`. The entry is not cleared.
  - `ret_f` only, empty: `level` stays 0, `underflow <= 1`.
  - `call` and `ret_f`, not empty: `mem[level-1] <= pc_in`, `level` unchanged (tail-call replace).
  - `call` and `ret_f`, empty: treated as push, `level` becomes 1, `underflow <= 1`.
  - Neither: hold.
- `rst` high at an edge: `level <= 0`, `overflow <= 0`, `underflow <= 0`.
  - Array contents are not cleared; they are unobservable because `ret_data` is forced to 0 when empty.
  - `rst` overrides any simultaneous `call`/`ret_f`.
- Sticky flags clear only on `rst`.
- `level` never exceeds `DEPTH` and never wraps below 0.

## Timing
- Reset values: `ret_data` 0, `level` 0, `empty` 1, `full` 0, `overflow` 0, `underflow` 0. They appear from the first edge with `rst` high.
- Push latency: a pushed value appears on `ret_data` one cycle after the `call` edge.
- Pop latency: after a `ret_f` edge, `ret_data` shows the next-older entry (or 0) in the following cycle.
- No handshake; requests are single-cycle pulses and back-to-back pushes/pops every cycle are legal.
- `empty`, `full` and `level` all update at the same edge as the pointer.

## Structure
- Shared package `cpu_pkg`: `CNTR_WIDTH` default and an address typedef `pc_t`, shared with the program counter.
- Sub-module `stack_mem`: synchronous-write, asynchronous-read register array. Ports: `clk`, `we`, `waddr`, `wdata`, `raddr`, `rdata`.
- `return_stack` holds only pointer, flag and next-state logic.

## Test plan
- Reset and pop on empty:
  - Reset, then `ret_f` for 1 cycle: `level` 0, `ret_data` 0, `underflow` 1.
  - Assert `rst`: `underflow` 0.
- Nested calls:
  - Push 0x10, 0x20, 0x30 on successive cycles: `level` 3, `ret_data` 0x30.
  - Three pops: `ret_data` reads 0x30, 0x20, 0x10 in the pop cycles, then 0 with `empty` 1.
- Overflow (DEPTH=8):
  - Push 0x01..0x08: `full` 1.
  - Push 0x09: `overflow` 1, `level` 8, `ret_data` 0x08.
  - 8 pops return 0x08..0x01.
- Simultaneous call and return:
  - Push 0x10, 0x20, then `call`+`ret_f` with `pc_in` 0x44: `level` 2, `ret_data` 0x44.
  - Pop: `ret_data` 0x10.
- Simultaneous on empty:
  - `call`+`ret_f` with `pc_in` 0x05 while empty: `level` 1, `ret_data` 0x05, `underflow` 1.
- Reset mid-operation:
  - Push 3 entries, assert `rst` in the same cycle as `call` 0x77: `level` 0, `ret_data` 0.
  - Next push 0x11: `ret_data` 0x11.
